// File: rtl/traffic_light_judge.sv
// Per-frame red/green pixel accumulator with a frame verdict and an N-frame
// debounce that commits a stable traffic-light state.
module traffic_light_judge #(
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 319,
    parameter int Y_MIN          = 0,
    parameter int Y_MAX          = 239,
    parameter int V_MIN          = 64,
    parameter int PIX_THRESH     = 200,
    parameter int CONFIRM_FRAMES = 3,
    parameter int CNT_W          = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_valid,
    input  logic [9:0]       x_pixel,
    input  logic [8:0]       y_pixel,
    input  logic [1:0]       r_g_decision,
    input  logic [7:0]       v_data,
    input  logic             frame_end,
    output logic [1:0]       light_state,
    output logic [1:0]       frame_verdict,
    output logic [CNT_W-1:0] red_count,
    output logic [CNT_W-1:0] green_count,
    output logic             frame_done,
    output logic             state_changed
);

    typedef enum logic [1:0] {
        ST_RED     = 2'd0,
        ST_GREEN   = 2'd1,
        ST_UNKNOWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [3:0]       CONFIRM = 4'(CONFIRM_FRAMES);

    logic [CNT_W-1:0] r_red_acc, r_green_acc;
    logic [CNT_W-1:0] r_red_count, r_green_count;
    state_t           r_verdict, r_cand, r_state;
    logic [3:0]       r_streak;
    logic             r_frame_done, r_state_changed;

    int               w_x, w_y, w_v, w_red_i, w_green_i;
    logic             w_qual, w_red_hit, w_green_hit, w_commit;
    logic [CNT_W-1:0] w_red_nxt, w_green_nxt;
    state_t           w_verdict, w_cand_nxt, w_state_nxt;
    logic [3:0]       w_streak_nxt;

    // Compare in int so zero-valued bounds don't turn into constant-true checks.
    assign w_x = int'(x_pixel);
    assign w_y = int'(y_pixel);
    assign w_v = int'(v_data);

    assign w_qual = pix_valid && (w_x >= X_MIN) && (w_x <= X_MAX) &&
                    (w_y >= Y_MIN) && (w_y <= Y_MAX) && (w_v >= V_MIN);
    assign w_red_hit   = w_qual && (r_g_decision == 2'd0);
    assign w_green_hit = w_qual && (r_g_decision == 2'd1);

    assign w_red_nxt   = (w_red_hit && r_red_acc != CNT_MAX)     ? r_red_acc + CNT_W'(1)   : r_red_acc;
    assign w_green_nxt = (w_green_hit && r_green_acc != CNT_MAX) ? r_green_acc + CNT_W'(1) : r_green_acc;

    assign w_red_i   = int'(w_red_nxt);
    assign w_green_i = int'(w_green_nxt);

    // Verdict and debounce operate on the values being latched this cycle.
    always_comb begin
        w_verdict = ST_UNKNOWN;
        if (w_red_i >= PIX_THRESH && w_red_nxt > w_green_nxt)
            w_verdict = ST_RED;
        else if (w_green_i >= PIX_THRESH && w_green_nxt > w_red_nxt)
            w_verdict = ST_GREEN;
    end

    always_comb begin
        w_cand_nxt   = r_cand;
        w_streak_nxt = r_streak;
        if (w_verdict == r_cand) begin
            w_streak_nxt = (r_streak >= CONFIRM) ? CONFIRM : r_streak + 4'd1;
        end else begin
            w_cand_nxt   = w_verdict;
            w_streak_nxt = 4'd1;
        end
    end

    assign w_commit = frame_end && (w_streak_nxt == CONFIRM);

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_UNKNOWN;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_commit) begin
            case (w_cand_nxt)
                ST_RED:   w_state_nxt = ST_RED;
                ST_GREEN: w_state_nxt = ST_GREEN;
                default:  w_state_nxt = ST_UNKNOWN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_red_acc       <= '0;
            r_green_acc     <= '0;
            r_red_count     <= '0;
            r_green_count   <= '0;
            r_verdict       <= ST_UNKNOWN;
            r_cand          <= ST_UNKNOWN;
            r_streak        <= 4'd0;
            r_frame_done    <= 1'b0;
            r_state_changed <= 1'b0;
        end else begin
            r_frame_done    <= frame_end;
            r_state_changed <= (w_state_nxt != r_state);
            if (frame_end) begin
                r_red_count   <= w_red_nxt;
                r_green_count <= w_green_nxt;
                r_verdict     <= w_verdict;
                r_cand        <= w_cand_nxt;
                r_streak      <= w_streak_nxt;
                r_red_acc     <= '0;
                r_green_acc   <= '0;
            end else begin
                r_red_acc     <= w_red_nxt;
                r_green_acc   <= w_green_nxt;
            end
        end
    end

    assign light_state   = r_state;
    assign frame_verdict = r_verdict;
    assign red_count     = r_red_count;
    assign green_count   = r_green_count;
    assign frame_done    = r_frame_done;
    assign state_changed = r_state_changed;

endmodule

// File: tb/tb_traffic_light_judge.sv
// Randomized bench for traffic_light_judge against a frame-level reference
// model (pixel tallies, verdict rule, verdict-history debounce).
module tb_traffic_light_judge;

    localparam int X_MIN = 0, X_MAX = 319, Y_MIN = 0, Y_MAX = 239;
    localparam int V_MIN = 64, PIX_THRESH = 200, CF = 3, CNT_W = 17;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             pix_valid = 1'b0;
    logic [9:0]       x_pixel = '0;
    logic [8:0]       y_pixel = '0;
    logic [1:0]       r_g_decision = '0;
    logic [7:0]       v_data = '0;
    logic             frame_end = 1'b0;
    logic [1:0]       light_state, frame_verdict;
    logic [CNT_W-1:0] red_count, green_count;
    logic             frame_done, state_changed;
    logic [1:0]       s_light, s_verdict;
    logic [3:0]       s_red, s_green;
    logic             s_done, s_chg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    traffic_light_judge dut (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .x_pixel(x_pixel),
        .y_pixel(y_pixel), .r_g_decision(r_g_decision), .v_data(v_data),
        .frame_end(frame_end), .light_state(light_state), .frame_verdict(frame_verdict),
        .red_count(red_count), .green_count(green_count), .frame_done(frame_done),
        .state_changed(state_changed)
    );

    // Narrow-counter instance: saturation and immediate commit.
    traffic_light_judge #(.PIX_THRESH(5), .CONFIRM_FRAMES(1), .CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid), .x_pixel(x_pixel),
        .y_pixel(y_pixel), .r_g_decision(r_g_decision), .v_data(v_data),
        .frame_end(frame_end), .light_state(s_light), .frame_verdict(s_verdict),
        .red_count(s_red), .green_count(s_green), .frame_done(s_done),
        .state_changed(s_chg)
    );

    // ---------------- reference model ----------------
    int m_red, m_green, m_rc, m_gc, m_verd, m_light;
    bit m_done, m_chg;
    int m_hist[$];

    function automatic int verdict_of(input int r, input int g);
        if (r >= PIX_THRESH && r > g) return 0;
        if (g >= PIX_THRESH && g > r) return 1;
        return 2;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_red = 0; m_green = 0; m_rc = 0; m_gc = 0; m_verd = 2; m_light = 2;
            m_done = 0; m_chg = 0; m_hist.delete();
        end else begin
            if (pix_valid && x_pixel >= X_MIN && x_pixel <= X_MAX && y_pixel >= Y_MIN &&
                y_pixel <= Y_MAX && v_data >= V_MIN) begin
                if (r_g_decision == 2'd0 && m_red < MAXC) m_red++;
                if (r_g_decision == 2'd1 && m_green < MAXC) m_green++;
            end
            m_done = frame_end;
            m_chg = 0;
            if (frame_end) begin
                bit same;
                m_rc = m_red; m_gc = m_green; m_red = 0; m_green = 0;
                m_verd = verdict_of(m_rc, m_gc);
                m_hist.push_back(m_verd);
                if (m_hist.size() > CF) void'(m_hist.pop_front());
                // Commit when the last CF verdicts all agree.
                same = (m_hist.size() == CF);
                foreach (m_hist[i]) if (m_hist[i] != m_verd) same = 0;
                if (same) begin
                    m_chg = (m_light != m_verd);
                    m_light = m_verd;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input int x, input int y, input int d,
                         input int vd, input logic fe);
        @(negedge clk);
        pix_valid = v; x_pixel = 10'(x); y_pixel = 9'(y);
        r_g_decision = 2'(d); v_data = 8'(vd); frame_end = fe;
    endtask

    task automatic roi_pix(input int d, input logic fe);
        drive(1'b1, $urandom_range(X_MAX, X_MIN), $urandom_range(Y_MAX, Y_MIN), d,
              $urandom_range(255, V_MIN), fe);
    endtask

    task automatic noise_pix();
        int d;
        d = $urandom_range(3, 0);
        case ($urandom_range(3, 0))
            0: drive(1'b1, $urandom_range(1023, X_MAX + 1), Y_MIN, d, 200, 1'b0);
            1: drive(1'b1, X_MIN, $urandom_range(511, Y_MAX + 1), d, 200, 1'b0);
            2: drive(1'b1, X_MAX, Y_MAX, d, $urandom_range(V_MIN - 1, 0), 1'b0);
            default: drive(1'b0, X_MIN, Y_MIN, d, 255, 1'b0);
        endcase
    endtask

    // Shuffled mix of red / green / unclassified ROI pixels plus masked noise,
    // then a frame_end cycle with no pixel.
    task automatic send_frame(input int nr, input int ng, input int nn, input int nz);
        int r, g, n, z, k;
        r = nr; g = ng; n = nn; z = nz;
        while (r + g + n + z > 0) begin
            k = $urandom_range(r + g + n + z - 1, 0);
            if (k < r) begin roi_pix(0, 1'b0); r--; end
            else if (k < r + g) begin roi_pix(1, 1'b0); g--; end
            else if (k < r + g + n) begin roi_pix($urandom_range(3, 2), 1'b0); n--; end
            else begin noise_pix(); z--; end
        end
        drive(1'b0, 0, 0, 2, 0, 1'b1);
    endtask

    task automatic settle();
        @(negedge clk);
        pix_valid = 1'b0; frame_end = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset_n = 1'b0; pix_valid = 1'b0; frame_end = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) roi_pix(i % 2, (i == 1));
        @(negedge clk);
        n_checks++;
        if ({light_state, frame_verdict, frame_done, state_changed} !== {2'd2, 2'd2, 1'b0, 1'b0} ||
            red_count !== '0 || green_count !== '0) begin
            n_errors++;
            $display("FAIL reset_state: light=%0d verdict=%0d rc=%0d gc=%0d done=%0b chg=%0b, want 2 2 0 0 0 0",
                     light_state, frame_verdict, red_count, green_count, frame_done, state_changed);
        end
        reset_n = 1'b1; pix_valid = 1'b0;
        send_frame(0, 0, 0, 0);
        settle();
        n_checks++;
        if (frame_verdict !== 2'd2 || frame_done !== 1'b1 || red_count !== '0) begin
            n_errors++;
            $display("FAIL empty_frame: verdict=%0d done=%0b rc=%0d, want 2 1 0",
                     frame_verdict, frame_done, red_count);
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL done_one_cycle: done=%0b, want 0", frame_done);
        end
    endtask

    task automatic test_red_debounce();
        int exp_light[3] = '{2, 2, 0};
        do_reset(2);
        for (int f = 0; f < 3; f++) begin
            send_frame(300, 0, 20, 30);
            settle();
            n_checks++;
            if (light_state !== 2'(exp_light[f]) || state_changed !== (f == 2) ||
                red_count !== CNT_W'(300) || frame_verdict !== 2'd0) begin
                n_errors++;
                $display("FAIL red_debounce f%0d: light=%0d chg=%0b rc=%0d verdict=%0d, want %0d %0b 300 0",
                         f, light_state, state_changed, red_count, frame_verdict, exp_light[f], (f == 2));
            end
        end
    endtask

    task automatic test_tie_interrupt();
        int seq[6] = '{1, 1, 0, 1, 1, 1};
        do_reset(1);
        send_frame(250, 250, 0, 10);
        settle();
        n_checks++;
        if (frame_verdict !== 2'd2 || red_count !== CNT_W'(250) || green_count !== CNT_W'(250)) begin
            n_errors++;
            $display("FAIL tie: verdict=%0d rc=%0d gc=%0d, want 2 250 250",
                     frame_verdict, red_count, green_count);
        end
        foreach (seq[f]) begin
            if (seq[f] == 1) send_frame(10, 300, 5, 5);
            else send_frame(300, 10, 5, 5);
            settle();
            n_checks++;
            if (light_state !== ((f == 5) ? 2'd1 : 2'd2) || state_changed !== (f == 5) ||
                light_state !== 2'(m_light)) begin
                n_errors++;
                $display("FAIL interrupt f%0d: light=%0d chg=%0b, want %0d %0b",
                         f, light_state, state_changed, (f == 5) ? 1 : 2, (f == 5));
            end
        end
    endtask

    task automatic test_masking();
        do_reset(1);
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 500; i++) begin
                case (m)
                    0: drive(1'b1, X_MAX + 1, $urandom_range(Y_MAX, Y_MIN), 0, 200, 1'b0);
                    1: drive(1'b1, $urandom_range(X_MAX, X_MIN), $urandom_range(Y_MAX, Y_MIN), 0, V_MIN - 1, 1'b0);
                    default: drive(1'b0, $urandom_range(X_MAX, X_MIN), $urandom_range(Y_MAX, Y_MIN), 0, 200, 1'b0);
                endcase
            end
            drive(1'b0, 0, 0, 2, 0, 1'b1);
            settle();
            n_checks++;
            if (red_count !== '0 || frame_verdict !== 2'd2) begin
                n_errors++;
                $display("FAIL mask_%0d: rc=%0d verdict=%0d, want 0 2", m, red_count, frame_verdict);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, X_MIN, Y_MIN, 0, V_MIN, 1'b0);
            drive(1'b1, X_MAX, Y_MAX, 0, V_MIN, 1'b0);
            drive(1'b1, X_MIN, Y_MAX, 0, V_MIN, 1'b0);
            drive(1'b1, X_MAX, Y_MIN, 0, V_MIN, 1'b0);
            drive(1'b1, X_MAX, Y_MAX + 1, 0, V_MIN, 1'b0);
        end
        drive(1'b0, 0, 0, 2, 0, 1'b1);
        settle();
        n_checks++;
        if (red_count !== CNT_W'(8)) begin
            n_errors++;
            $display("FAIL roi_edges: rc=%0d, want 8", red_count);
        end
    endtask

    task automatic test_coincident_saturation();
        do_reset(1);
        for (int i = 0; i < 10; i++) roi_pix(0, 1'b0);
        roi_pix(0, 1'b1);
        settle();
        n_checks++;
        if (red_count !== CNT_W'(11)) begin
            n_errors++;
            $display("FAIL coincident: rc=%0d, want 11", red_count);
        end
        send_frame(0, 0, 0, 0);
        settle();
        n_checks++;
        if (red_count !== '0) begin
            n_errors++;
            $display("FAIL next_frame_clear: rc=%0d, want 0", red_count);
        end
        do_reset(1);
        send_frame(20, 0, 0, 0);
        settle();
        n_checks++;
        if (s_red !== 4'd15 || red_count !== CNT_W'(20) || s_light !== 2'd0 || s_chg !== 1'b1) begin
            n_errors++;
            $display("FAIL saturate: small_rc=%0d rc=%0d small_light=%0d small_chg=%0b, want 15 20 0 1",
                     s_red, red_count, s_light, s_chg);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        for (int i = 0; i < 150; i++) roi_pix(0, 1'b0);
        do_reset(1);
        send_frame(60, 0, 0, 0);
        settle();
        n_checks++;
        if (red_count !== CNT_W'(60) || light_state !== 2'd2) begin
            n_errors++;
            $display("FAIL mid_reset: rc=%0d light=%0d, want 60 2", red_count, light_state);
        end
    endtask

    task automatic test_random();
        int col, run;
        do_reset(1);
        col = 0; run = 0;
        for (int f = 0; f < 16; f++) begin
            if (run == 0) begin
                col = $urandom_range(2, 0);
                run = $urandom_range(4, 1);
            end
            run--;
            case (col)
                0: send_frame($urandom_range(400, 200), $urandom_range(190, 0), $urandom_range(30, 0), $urandom_range(30, 0));
                1: send_frame($urandom_range(190, 0), $urandom_range(400, 200), $urandom_range(30, 0), $urandom_range(30, 0));
                default: send_frame($urandom_range(199, 0), $urandom_range(199, 0), $urandom_range(30, 0), $urandom_range(30, 0));
            endcase
            settle();
            n_checks++;
            if (light_state !== 2'(m_light) || frame_verdict !== 2'(m_verd) ||
                red_count !== CNT_W'(m_rc) || green_count !== CNT_W'(m_gc) ||
                frame_done !== m_done || state_changed !== m_chg) begin
                n_errors++;
                $display("FAIL random f%0d: light=%0d/%0d verdict=%0d/%0d rc=%0d/%0d gc=%0d/%0d done=%0b/%0b chg=%0b/%0b",
                         f, light_state, m_light, frame_verdict, m_verd, red_count, m_rc,
                         green_count, m_gc, frame_done, m_done, state_changed, m_chg);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        for (int f = 0; f < 3; f++) send_frame(0, 300, 0, 0);
        // Three further back-to-back empty frames: unknown commits on the third.
        for (int f = 0; f < 3; f++) begin
            drive(1'b0, 0, 0, 2, 0, 1'b1);
            if (f > 0) begin
                n_checks++;
                if (frame_done !== 1'b1 || frame_verdict !== 2'd2 || light_state !== 2'd1 ||
                    light_state !== 2'(m_light)) begin
                    n_errors++;
                    $display("FAIL back_to_back f%0d: done=%0b verdict=%0d light=%0d, want 1 2 1",
                             f, frame_done, frame_verdict, light_state);
                end
            end
        end
        settle();
        n_checks++;
        if (light_state !== 2'd2 || state_changed !== 1'b1 || green_count !== '0) begin
            n_errors++;
            $display("FAIL back_to_back_commit: light=%0d chg=%0b gc=%0d, want 2 1 0",
                     light_state, state_changed, green_count);
        end
    endtask

    initial begin
        test_reset();
        test_red_debounce();
        test_tie_interrupt();
        test_masking();
        test_coincident_saturation();
        test_mid_reset();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
